// File: rtl/vote_sequencer_5.sv
// rtl/vote_sequencer_5.sv - windowed 5-voter collection with 3-of-5 majority decision
module vote_sequencer_5 #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:1] vote_valid,
    input  logic [5:1] vote,
    output logic       busy,
    output logic [5:1] cast_mask,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       result,
    output logic [2:0] yes_count,
    output logic       quorum,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_RESULT
    } state_t;

    state_t          state_q;
    logic [5:1]      mask_q;
    logic [5:1]      ballot_q;
    logic [TW-1:0]   timer_q;
    logic            busy_q;
    logic            valid_q;
    logic            result_q;
    logic [2:0]      yes_q;
    logic            quorum_q;
    logic            timed_out_q;

    logic [5:1]      accept_d;
    logic [5:1]      mask_d;
    logic [5:1]      ballot_d;
    logic            close_d;
    logic [2:0]      yes_d;
    logic [2:0]      cast_cnt_d;

    function automatic logic [2:0] popcount5(input logic [5:1] v);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 1; i <= 5; i++) begin
            cnt = cnt + 3'(v[i]);
        end
        return cnt;
    endfunction

    // Only voters not yet in the mask are latched, so the first ballot wins.
    always_comb begin
        accept_d   = vote_valid & ~mask_q;
        mask_d     = mask_q | accept_d;
        ballot_d   = ballot_q | (accept_d & vote);
        close_d    = (mask_d == 5'b11111) || (timer_q == TW'(TIMEOUT - 1));
        yes_d      = popcount5(mask_q & ballot_q);
        cast_cnt_d = popcount5(mask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            ballot_q    <= '0;
            timer_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= 1'b0;
            yes_q       <= '0;
            quorum_q    <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_COLLECT;
                        busy_q      <= 1'b1;
                        mask_q      <= '0;
                        ballot_q    <= '0;
                        timer_q     <= '0;
                        result_q    <= 1'b0;
                        yes_q       <= '0;
                        quorum_q    <= 1'b0;
                        timed_out_q <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    mask_q   <= mask_d;
                    ballot_q <= ballot_d;
                    timer_q  <= timer_q + TW'(1);
                    if (close_d) begin
                        state_q <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    yes_q       <= yes_d;
                    result_q    <= (yes_d >= 3'd3);
                    quorum_q    <= (cast_cnt_d >= 3'd3);
                    timed_out_q <= (mask_q != 5'b11111);
                    valid_q     <= 1'b1;
                    state_q     <= S_RESULT;
                end
                S_RESULT: begin
                    if (result_ready) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign cast_mask    = mask_q;
    assign result_valid = valid_q;
    assign result       = result_q;
    assign yes_count    = yes_q;
    assign quorum       = quorum_q;
    assign timed_out    = timed_out_q;

endmodule

// File: tb/tb_vote_sequencer_5.sv
// tb/tb_vote_sequencer_5.sv - directed and randomized windows against a window-level vote model
module tb_vote_sequencer_5;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:1] vote_valid;
    logic [5:1] vote;
    logic       result_ready;

    logic       busy_w  [3];
    logic       valid_w [3];
    logic       res_w   [3];
    logic       quo_w   [3];
    logic       to_w    [3];
    logic [5:1] cm_w    [3];
    logic [2:0] yc_w    [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vote_sequencer_5 #(.TIMEOUT(16), .TW(8)) u_t16 (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
        .busy(busy_w[0]), .cast_mask(cm_w[0]), .result_valid(valid_w[0]),
        .result_ready(result_ready), .result(res_w[0]), .yes_count(yc_w[0]),
        .quorum(quo_w[0]), .timed_out(to_w[0])
    );
    vote_sequencer_5 #(.TIMEOUT(4), .TW(8)) u_t4 (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
        .busy(busy_w[1]), .cast_mask(cm_w[1]), .result_valid(valid_w[1]),
        .result_ready(result_ready), .result(res_w[1]), .yes_count(yc_w[1]),
        .quorum(quo_w[1]), .timed_out(to_w[1])
    );
    vote_sequencer_5 #(.TIMEOUT(3), .TW(8)) u_t3 (
        .clk(clk), .rst(rst), .start(start), .vote_valid(vote_valid), .vote(vote),
        .busy(busy_w[2]), .cast_mask(cm_w[2]), .result_valid(valid_w[2]),
        .result_ready(result_ready), .result(res_w[2]), .yes_count(yc_w[2]),
        .quorum(quo_w[2]), .timed_out(to_w[2])
    );

    // Stimulus per cycle of a window; cycle 0 is the start cycle.
    logic [5:1] s_vv    [0:31];
    logic [5:1] s_vt    [0:31];
    logic       s_start [0:31];

    // Prediction for one window.
    int         p_close;
    logic [5:1] p_mask [0:31];
    logic [5:1] p_fmask;
    logic [2:0] p_yes;
    logic       p_res;
    logic       p_quo;
    logic       p_to;

    function automatic int tmo(input int k);
        return (k == 0) ? 16 : (k == 1) ? 4 : 3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic clear_stim();
        for (int n = 0; n < 32; n++) begin
            s_vv[n]    = '0;
            s_vt[n]    = '0;
            s_start[n] = 1'b0;
        end
        s_start[0] = 1'b1;
    endtask

    // Window closes on the first cycle where every voter has a ballot, or after T cycles.
    task automatic predict(input int k);
        logic [5:1] mask;
        logic [5:1] yes;
        int t;
        t = tmo(k);
        mask = '0;
        yes  = '0;
        p_mask[0] = '0;
        p_mask[1] = '0;
        p_close = t;
        for (int j = 1; j <= t; j++) begin
            for (int v = 1; v <= 5; v++) begin
                if (s_vv[j][v] && !mask[v]) begin
                    mask[v] = 1'b1;
                    yes[v]  = s_vt[j][v];
                end
            end
            p_mask[j+1] = mask;
            if (mask == 5'b11111) begin
                p_close = j;
                break;
            end
        end
        p_fmask = mask;
        p_yes   = 3'($countones(yes));
        p_res   = ($countones(yes) >= 3);
        p_quo   = ($countones(mask) >= 3);
        p_to    = (mask != 5'b11111);
    endtask

    task automatic check_zero(input int k, input string tag);
        chk({tag, ".busy"},  8'(busy_w[k]),  8'd0);
        chk({tag, ".valid"}, 8'(valid_w[k]), 8'd0);
        chk({tag, ".mask"},  8'(cm_w[k]),    8'd0);
        chk({tag, ".res"},   8'(res_w[k]),   8'd0);
        chk({tag, ".yes"},   8'(yc_w[k]),    8'd0);
        chk({tag, ".quo"},   8'(quo_w[k]),   8'd0);
        chk({tag, ".to"},    8'(to_w[k]),    8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; vote_valid = '0; vote = '0; result_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) check_zero(k, "reset");
    endtask

    task automatic run_window(input int k, input int hold);
        int  last;
        logic fin;
        logic [5:1] emask;
        predict(k);
        last = p_close + hold + 4;
        for (int n = 0; n <= last; n++) begin
            @(negedge clk);
            cyc   = n;
            fin   = (n >= p_close + 2);
            emask = (n <= p_close + 1) ? p_mask[n] : p_fmask;
            chk("busy",  8'(busy_w[k]),  8'(n >= 1 && n <= p_close + 2 + hold));
            chk("valid", 8'(valid_w[k]), 8'(n >= p_close + 2 && n <= p_close + 2 + hold));
            chk("mask",  8'(cm_w[k]),    8'(emask));
            chk("res",   8'(res_w[k]),   fin ? 8'(p_res) : 8'd0);
            chk("yes",   8'(yc_w[k]),    fin ? 8'(p_yes) : 8'd0);
            chk("quo",   8'(quo_w[k]),   fin ? 8'(p_quo) : 8'd0);
            chk("to",    8'(to_w[k]),    fin ? 8'(p_to)  : 8'd0);
            start      = (n <= p_close + 2 + hold) ? s_start[n] : 1'b0;
            vote_valid = s_vv[n];
            vote       = s_vt[n];
            if (n < p_close + 2)
                result_ready = 1'($urandom_range(0, 1));
            else
                result_ready = (n == p_close + 2 + hold);
        end
        start = 1'b0; vote_valid = '0; result_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vote_valid = '0; vote = '0; result_ready = 1'b0;

        // all five vote at once
        do_reset();
        clear_stim();
        s_vv[1] = 5'b11111; s_vt[1] = 5'b00111;
        run_window(0, 0);

        // staggered votes with a duplicate re-strobe
        do_reset();
        clear_stim();
        s_vv[1] = 5'b00011; s_vt[1] = 5'b00011;
        s_vv[2] = 5'b00001; s_vt[2] = 5'b00000;
        s_vv[4] = 5'b11100; s_vt[4] = 5'b10000;
        run_window(0, 0);

        // timeout with TIMEOUT=4
        do_reset();
        clear_stim();
        s_vv[1] = 5'b10010; s_vt[1] = 5'b10010;
        run_window(1, 1);

        // backpressure with start pulses in RESULT
        do_reset();
        clear_stim();
        s_vv[1] = 5'b11111; s_vt[1] = 5'b00111;
        s_start[4] = 1'b1; s_start[6] = 1'b1; s_start[8] = 1'b1;
        run_window(0, 5);

        // reset mid-COLLECT, then a fresh window must not see old ballots
        do_reset();
        @(negedge clk); cyc = 0; start = 1'b1;
        @(negedge clk); start = 1'b0; vote_valid = 5'b00011; vote = 5'b00011;
        @(negedge clk); vote_valid = '0;
        chk("midrst.premask", 8'(cm_w[0]), 8'h03);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check_zero(0, "midrst");
        clear_stim();
        s_vv[1] = 5'b11100; s_vt[1] = 5'b11100;
        s_vv[2] = 5'b00011; s_vt[2] = 5'b00011;
        run_window(0, 0);

        // late vote exactly at the TIMEOUT=3 boundary
        do_reset();
        clear_stim();
        s_vv[1] = 5'b11011; s_vt[1] = 5'b01011;
        s_vv[3] = 5'b00100; s_vt[3] = 5'b00100;
        run_window(2, 0);

        // randomized windows
        for (int w = 0; w < 30; w++) begin
            int k;
            int dens;
            k    = $urandom_range(0, 2);
            dens = $urandom_range(1, 4);
            do_reset();
            clear_stim();
            for (int n = 0; n < 32; n++) begin
                s_vv[n] = ($urandom_range(0, dens) == 0) ? 5'($urandom) : 5'b00000;
                s_vt[n] = 5'($urandom);
                if (n > 0) s_start[n] = ($urandom_range(0, 3) == 0);
            end
            run_window(k, $urandom_range(0, 5));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
